// File: rtl/com_fifo_pkg.sv
// Shared sizing helpers for the com_* FIFO family.
package com_fifo_pkg;

    localparam int PREFETCH_DEPTH = 2;

    function automatic int cnt_w(input int cap);
        return $clog2(cap + 1);
    endfunction

endpackage

// File: rtl/com_tpram_reg.sv
// Simple two-port RAM with byte-lane write strobes and a registered, read-first output.
module com_tpram_reg #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    parameter  int STRB_W = 1,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LANE_W = DATA_W / STRB_W
) (
    input  logic              i_wr_clk,
    input  logic [STRB_W-1:0] i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_clk,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_wr_clk) begin
        for (int s = 0; s < STRB_W; s++) begin
            if (i_wr_en[s]) begin
                r_mem[i_wr_addr][s*LANE_W +: LANE_W] <= i_wr_data[s*LANE_W +: LANE_W];
            end
        end
    end

    // Read-first: a same-address write in this cycle is not visible until the next read.
    always_ff @(posedge i_rd_clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/com_sfifo_fwft.sv
// Single-clock FWFT FIFO: RAM body plus a 2-entry register queue that hides the RAM read latency.
module com_sfifo_fwft
    import com_fifo_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int DEPTH     = 64,
    parameter  int AFULL_TH  = 60,
    parameter  int AEMPTY_TH = 2,
    localparam int CAP       = DEPTH + PREFETCH_DEPTH,
    localparam int CNT_W     = cnt_w(DEPTH + PREFETCH_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  count,
    output logic              afull,
    output logic              aempty
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int RCNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAP);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [RCNT_W-1:0] r_ram_cnt;
    logic              r_inflight;
    logic [1:0]        r_q_cnt;
    logic              r_q_head;
    logic              r_q_tail;
    logic [DATA_W-1:0] r_q [2];
    logic [CNT_W-1:0]  r_count;
    logic              r_afull;
    logic              r_aempty;

    logic              w_clr;
    logic              w_push;
    logic              w_pop;
    logic              w_rd_en;
    logic [2:0]        w_q_occ;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_rd_data;

    assign w_clr   = rst | flush;
    assign s_ready = (r_count < CAP_C);
    assign m_valid = (r_q_cnt != 2'd0);
    assign w_push  = s_valid & s_ready & ~w_clr;
    assign w_pop   = m_valid & m_ready & ~w_clr;

    // Issue a read whenever the queue (including the read already in flight) will have a free slot.
    assign w_q_occ = {1'b0, r_q_cnt} + {2'b00, r_inflight};
    assign w_rd_en = (r_ram_cnt != '0) && ((w_q_occ - {2'b00, w_pop}) < 3'd2) && !w_clr;

    assign m_data = r_q[r_q_head];
    assign count  = r_count;
    assign afull  = r_afull;
    assign aempty = r_aempty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_q_cnt    <= 2'd0;
            r_q_head   <= 1'b0;
            r_q_tail   <= 1'b0;
            r_count    <= '0;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_rd_en})
                2'b10:   r_ram_cnt <= r_ram_cnt + RCNT_W'(1);
                2'b01:   r_ram_cnt <= r_ram_cnt - RCNT_W'(1);
                default: r_ram_cnt <= r_ram_cnt;
            endcase
            case ({r_inflight, w_pop})
                2'b10:   r_q_cnt <= r_q_cnt + 2'd1;
                2'b01:   r_q_cnt <= r_q_cnt - 2'd1;
                default: r_q_cnt <= r_q_cnt;
            endcase
            r_inflight <= w_rd_en;
            r_q_head   <= r_q_head ^ w_pop;
            r_q_tail   <= r_q_tail ^ r_inflight;
            r_count    <= w_count_nxt;
            r_afull    <= (w_count_nxt >= AFULL_C);
            r_aempty   <= (w_count_nxt <= AEMPTY_C);
        end
    end

    // RAM output is only meaningful the cycle after a read was issued.
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_q[r_q_tail] <= w_rd_data;
        end
    end

    com_tpram_reg #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .STRB_W (1)
    ) u_ram (
        .i_wr_clk  (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (s_data),
        .i_rd_clk  (clk),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

endmodule

// File: tb/tb_com_sfifo_fwft.sv
// Bench for com_sfifo_fwft: table vectors, directed corner sequences and a random scoreboard run.
module tb_com_sfifo_fwft;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 64;
    localparam int AFULL_TH  = 60;
    localparam int AEMPTY_TH = 2;
    localparam int CAP       = DEPTH + 2;
    localparam int CNT_W     = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  count;
    logic              afull;
    logic              aempty;

    always #5 clk = ~clk;

    com_sfifo_fwft #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count),
        .afull   (afull),
        .aempty  (aempty)
    );

    // Reference: ordered list of stored words with the cycle each was accepted.
    // A word is presented at the head once it is at the front and 3 cycles old.
    typedef struct {
        logic [31:0] data;
        int          pc;
    } ent_t;

    typedef struct {
        logic        sv;
        logic [31:0] d;
        logic        mr;
        logic        e_mv;
        logic [31:0] e_md;
        int          e_cnt;
        logic        e_ae;
    } vec_t;

    ent_t mdl_q[$];
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   n_pops;

    function automatic bit mdl_mvalid();
        return (mdl_q.size() > 0) && (cyc >= mdl_q[0].pc + 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        int n;
        n = mdl_q.size();
        chk("m_valid", 32'(m_valid), 32'(mdl_mvalid()));
        if (mdl_mvalid()) chk("m_data", m_data, mdl_q[0].data);
        chk("count", 32'(count), n);
        chk("s_ready", 32'(s_ready), 32'(n < CAP));
        chk("afull", 32'(afull), 32'(n >= AFULL_TH));
        chk("aempty", 32'(aempty), 32'(n <= AEMPTY_TH));
    endtask

    task automatic step(input logic sv, input logic [31:0] d, input logic mr,
                        input logic rs, input logic fl);
        bit   push;
        bit   pop;
        ent_t e;
        check_model();
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        rst     = rs;
        flush   = fl;
        push = sv && (mdl_q.size() < CAP) && !rs && !fl;
        pop  = mr && mdl_mvalid() && !rs && !fl;
        @(posedge clk);
        if (rs || fl) begin
            mdl_q.delete();
        end else begin
            if (pop) begin
                void'(mdl_q.pop_front());
                n_pops++;
            end
            if (push) begin
                e.data = d;
                e.pc   = cyc;
                mdl_q.push_back(e);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_s_ready"}, 32'(s_ready), 1);
        chk({tag, "_afull"}, 32'(afull), 0);
        chk({tag, "_aempty"}, 32'(aempty), 1);
    endtask

    vec_t t1[5];

    initial begin
        int p0;
        int guard;
        n_checks = 0;
        n_errors = 0;
        n_pops   = 0;
        cyc      = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mdl_q.delete();
        chk_reset_state("init");

        // Single word latency through an empty FIFO.
        t1[0] = '{1'b1, 32'hA5, 1'b1, 1'b0, 32'h0,  0, 1'b1};
        t1[1] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1, 1'b1};
        t1[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1, 1'b1};
        t1[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA5, 1, 1'b1};
        t1[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            chk("t1_m_valid", 32'(m_valid), 32'(t1[i].e_mv));
            if (t1[i].e_mv) chk("t1_m_data", m_data, t1[i].e_md);
            chk("t1_count", 32'(count), t1[i].e_cnt);
            chk("t1_aempty", 32'(aempty), 32'(t1[i].e_ae));
            step(t1[i].sv, t1[i].d, t1[i].mr, 1'b0, 1'b0);
        end

        // Fill to capacity with the consumer stalled.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < CAP; i++) begin
            if (i == 59) chk("fill_afull59", 32'(afull), 0);
            if (i == 60) chk("fill_afull60", 32'(afull), 1);
            step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        end
        chk("full_count", 32'(count), CAP);
        chk("full_s_ready", 32'(s_ready), 0);
        chk("full_afull", 32'(afull), 1);
        step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        chk("full_reject_count", 32'(count), CAP);
        // Push and pop together at full: only the pop happens.
        step(1'b1, 32'd100, 1'b1, 1'b0, 1'b0);
        chk("fullpop_count", 32'(count), CAP - 1);
        chk("fullpop_s_ready", 32'(s_ready), 1);
        step(1'b1, 32'd101, 1'b0, 1'b0, 1'b0);
        chk("refill_count", 32'(count), CAP);
        for (int i = 0; i < CAP + 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_count", 32'(count), 0);

        // Continuous streaming.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        p0 = n_pops;
        for (int i = 0; i < 1000; i++) begin
            if (i >= 3) begin
                chk("stream_count", 32'(count), 3);
                chk("stream_m_valid", 32'(m_valid), 1);
            end
            step(1'b1, 32'(i + 32'h1000), 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("stream_pops", 32'(n_pops - p0), 1000);

        // Flush with a read in flight.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 32'(32'h500 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("preflush_count", 32'(count), 10);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_reset_state("flush");
        step(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("postflush_m_valid", 32'(m_valid), 1);
        chk("postflush_m_data", m_data, 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Random traffic with a reset pulse partway through.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        p0 = n_pops;
        guard = 0;
        while ((n_pops - p0) < 10000 && guard < 70000) begin
            if (guard == 20000) begin
                step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
                chk_reset_state("midrst");
            end else begin
                step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
            guard++;
        end
        chk("random_budget", 32'(guard < 70000), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
